// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM/WB stage and its lane-alignment helper.
//   - funct3 size encodings (low two bits) and the unsigned-load flag (bit 2)
//   - writeback exception codes
//   - bus FSM state enum
//   - positions of memread/memwrite above the carried writeback control bits
//   - sign/zero extension helpers for sub-word loads
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  // Offsets above the CTRL_WB_W writeback bits inside ctrl_mem.
  localparam int CTRL_MEMREAD_OFS  = 1;
  localparam int CTRL_MEMWRITE_OFS = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GWAIT = 2'b01,
    S_RWAIT = 2'b10
  } state_e;

  function automatic logic [31:0] extend8(input logic [7:0] v, input logic is_unsigned);
    return is_unsigned ? {24'h000000, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] v, input logic is_unsigned);
    return is_unsigned ? {16'h0000, v} : {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for 32-bit data memory accesses.
// Ports:
//   funct3_i      size/sign code of the access
//   addr_i        low two bits of the effective address
//   wdata_i       store data (value in the low lanes)
//   rdata_i       raw memory word
//   be_o          byte enables
//   wdata_o       store data replicated across all lanes
//   load_o        extracted and extended load value
//   misaligned_o  halfword on odd address or word not on a 4-byte boundary
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [31:0] byte_sh_s;
  logic [15:0] half_s;

  // Select the addressed byte/half of the memory word.
  always_comb begin
    byte_sh_s = rdata_i >> {addr_i, 3'b000};
    half_s    = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Per-size enables, store replication, load extension and alignment check.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = 32'h0000_0000;
    load_o       = 32'h0000_0000;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      SZ_B: begin
        be_o         = 4'b0001 << addr_i;
        wdata_o      = {4{wdata_i[7:0]}};
        load_o       = extend8(byte_sh_s[7:0], funct3_i[2]);
        misaligned_o = 1'b0;
      end
      SZ_H: begin
        be_o         = 4'b0011 << addr_i;
        wdata_o      = {2{wdata_i[15:0]}};
        load_o       = extend16(half_s, funct3_i[2]);
        misaligned_o = addr_i[0];
      end
      default: begin
        // Word, and any unused size code, behave as a full word.
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        load_o       = rdata_i;
        misaligned_o = (addr_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM pipeline stage driving a req/gnt/rvalid data-memory port and
// the MEM/WB pipeline register.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   valid_mem, ctrl_mem, funct3_mem, rd_mem, pc4_mem, alu_result, write_data1, flush
//                                    instruction fields arriving from EX/MEM
//   dmem_req/we/be, address, w_data  request side of the memory port
//   dmem_gnt, dmem_rvalid, read_data response side of the memory port
//   stall                            holds upstream while an access is outstanding
//   valid_wb, ctrl_wb, rd_wb, pc4_wb, alu_data, mem_data, exc_wb
//                                    registered MEM/WB outputs
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RD_W      = 32,
  parameter int CTRL_WB_W = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_mem,
  input  logic [CTRL_WB_W+1:0]   ctrl_mem,
  input  logic [2:0]             funct3_mem,
  input  logic [RD_W-1:0]        rd_mem,
  input  logic [XLEN-1:0]        pc4_mem,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        write_data1,
  input  logic                   flush,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [XLEN/8-1:0]      dmem_be,
  output logic [XLEN-1:0]        address,
  output logic [XLEN-1:0]        w_data,
  input  logic                   dmem_gnt,
  input  logic                   dmem_rvalid,
  input  logic [XLEN-1:0]        read_data,
  output logic                   stall,
  output logic                   valid_wb,
  output logic [CTRL_WB_W-1:0]   ctrl_wb,
  output logic [RD_W-1:0]        rd_wb,
  output logic [XLEN-1:0]        pc4_wb,
  output logic [XLEN-1:0]        alu_data,
  output logic [XLEN-1:0]        mem_data,
  output logic [1:0]             exc_wb
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               flush_seen_q;

  logic               memread_s, memwrite_s, busy_s, access_s, cnt_max_s;
  logic               req_s, misal_s, timeout_s, load_done_s, done_s;
  logic               misaligned_s;
  logic [XLEN-1:0]    load_ext_s;

  logic                 valid_wb_q, valid_wb_d;
  logic [CTRL_WB_W-1:0] ctrl_wb_q;
  logic [RD_W-1:0]      rd_wb_q;
  logic [XLEN-1:0]      pc4_wb_q, alu_data_q, mem_data_q, mem_data_d;
  logic [1:0]           exc_wb_q, exc_wb_d;

  assign memread_s  = ctrl_mem[CTRL_WB_W + CTRL_MEMREAD_OFS];
  assign memwrite_s = ctrl_mem[CTRL_WB_W + CTRL_MEMWRITE_OFS];

  lsu_align u_align (
    .funct3_i     (funct3_mem),
    .addr_i       (alu_result[1:0]),
    .wdata_i      (write_data1),
    .rdata_i      (read_data),
    .be_o         (dmem_be),
    .wdata_o      (w_data),
    .load_o       (load_ext_s),
    .misaligned_o (misaligned_s)
  );

  // Request/completion decode. Once a transaction is in flight it is committed,
  // so a late flush no longer withdraws it (upstream is held by stall).
  always_comb begin
    busy_s      = (state_q != S_IDLE);
    access_s    = busy_s | (valid_mem & ~flush & (memread_s | memwrite_s));
    cnt_max_s   = (cnt_q == CNT_W'(TIMEOUT - 1));
    req_s       = 1'b0;
    misal_s     = 1'b0;
    timeout_s   = 1'b0;
    load_done_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        misal_s = access_s & misaligned_s;
        req_s   = access_s & ~misaligned_s;
        done_s  = misal_s | (req_s & dmem_gnt & ~memread_s);
      end
      S_GWAIT: begin
        timeout_s = cnt_max_s & ~dmem_gnt;
        req_s     = ~timeout_s;
        done_s    = timeout_s | (dmem_gnt & ~memread_s);
      end
      S_RWAIT: begin
        load_done_s = dmem_rvalid;
        timeout_s   = cnt_max_s & ~dmem_rvalid;
        done_s      = dmem_rvalid | timeout_s;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign dmem_req = reset_n & req_s;
  assign dmem_we  = memwrite_s & ~memread_s;
  assign address  = {alu_result[XLEN-1:2], 2'b00};
  assign stall    = reset_n & access_s & ~done_s;

  // Bus FSM with its wait-cycle counter and the sticky mid-access flush flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q        <= '0;
          flush_seen_q <= 1'b0;
          if (req_s && dmem_gnt) begin
            state_q <= memread_s ? S_RWAIT : S_IDLE;
          end else if (req_s) begin
            state_q <= S_GWAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_GWAIT: begin
          if (timeout_s || (dmem_gnt && !memread_s)) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
          end else if (dmem_gnt) begin
            state_q      <= S_RWAIT;
            cnt_q        <= '0;
            flush_seen_q <= flush_seen_q | flush;
          end else begin
            cnt_q        <= cnt_q + CNT_W'(1);
            flush_seen_q <= flush_seen_q | flush;
          end
        end
        S_RWAIT: begin
          if (done_s) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
          end else begin
            cnt_q        <= cnt_q + CNT_W'(1);
            flush_seen_q <= flush_seen_q | flush;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          flush_seen_q <= 1'b0;
        end
      endcase
    end
  end

  // Next values for the MEM/WB register; a flush seen during the access kills it.
  always_comb begin
    valid_wb_d = valid_mem & ~(flush | flush_seen_q);
    mem_data_d = load_done_s ? load_ext_s : {XLEN{1'b0}};
    if (misal_s) begin
      exc_wb_d = EXC_MISALIGN;
    end else if (timeout_s) begin
      exc_wb_d = EXC_TIMEOUT;
    end else begin
      exc_wb_d = EXC_NONE;
    end
  end

  // MEM/WB register: load when not stalled, otherwise insert a bubble and hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_wb_q <= 1'b0;
      ctrl_wb_q  <= '0;
      rd_wb_q    <= '0;
      pc4_wb_q   <= '0;
      alu_data_q <= '0;
      mem_data_q <= '0;
      exc_wb_q   <= EXC_NONE;
    end else if (!stall) begin
      valid_wb_q <= valid_wb_d;
      ctrl_wb_q  <= ctrl_mem[CTRL_WB_W-1:0];
      rd_wb_q    <= rd_mem;
      pc4_wb_q   <= pc4_mem;
      alu_data_q <= alu_result;
      mem_data_q <= mem_data_d;
      exc_wb_q   <= exc_wb_d;
    end else begin
      valid_wb_q <= 1'b0;
    end
  end

  assign valid_wb = valid_wb_q;
  assign ctrl_wb  = ctrl_wb_q;
  assign rd_wb    = rd_wb_q;
  assign pc4_wb   = pc4_wb_q;
  assign alu_data = alu_data_q;
  assign mem_data = mem_data_q;
  assign exc_wb   = exc_wb_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed, self-checking bench for mem_wb_stage (default parameters).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_mem;
  logic [4:0]  ctrl_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] address, w_data;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] read_data;
  logic        stall, valid_wb;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb, pc4_wb, alu_data, mem_data;
  logic [1:0]  exc_wb;

  int total = 0;
  int bad   = 0;
  int stall_cnt;

  mem_wb_stage dut (
    .clk(clk), .reset_n(reset_n), .valid_mem(valid_mem), .ctrl_mem(ctrl_mem),
    .funct3_mem(funct3_mem), .rd_mem(rd_mem), .pc4_mem(pc4_mem),
    .alu_result(alu_result), .write_data1(write_data1), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .address(address),
    .w_data(w_data), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .read_data(read_data), .stall(stall), .valid_wb(valid_wb), .ctrl_wb(ctrl_wb),
    .rd_wb(rd_wb), .pc4_wb(pc4_wb), .alu_data(alu_data), .mem_data(mem_data),
    .exc_wb(exc_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {memread, memwrite, wb[2:0]}
  task automatic drive(input logic v, input logic [4:0] c, input logic [2:0] f3,
                       input logic [31:0] rd, input logic [31:0] addr, input logic [31:0] wd);
    valid_mem  = v;
    ctrl_mem   = c;
    funct3_mem = f3;
    rd_mem     = rd;
    pc4_mem    = addr + 32'd4;
    alu_result = addr;
    write_data1 = wd;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    read_data = 32'h0000_0000;
    drive(1'b1, 5'b01_101, 3'b010, 32'd1, 32'h0000_0100, 32'h1111_1111);
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid_wb", {31'd0, valid_wb}, 32'd0);
    chk("rst_alu_data", alu_data, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_exc", {30'd0, exc_wb}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;

    // sw 0xDEADBEEF @0x100, granted immediately
    drive(1'b1, 5'b01_101, 3'b010, 32'd5, 32'h0000_0100, 32'hDEAD_BEEF);
    dmem_gnt = 1'b1;
    #1;
    chk("sw_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    chk("sw_be", {28'd0, dmem_be}, 32'h0000_000F);
    chk("sw_wdata", w_data, 32'hDEAD_BEEF);
    chk("sw_addr", address, 32'h0000_0100);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sw_valid_wb", {31'd0, valid_wb}, 32'd1);
    chk("sw_ctrl_wb", {29'd0, ctrl_wb}, 32'd5);
    chk("sw_rd_wb", rd_wb, 32'd5);
    chk("sw_pc4_wb", pc4_wb, 32'h0000_0104);

    // lb @0x103: gnt one cycle late, rvalid three cycles after gnt
    drive(1'b1, 5'b10_011, 3'b000, 32'd9, 32'h0000_0103, 32'h0);
    dmem_gnt = 1'b0; read_data = 32'h80FF_FFFF; stall_cnt = 0;
    #1;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_be", {28'd0, dmem_be}, 32'h0000_0008);
    chk("lb_addr", address, 32'h0000_0100);
    if (stall) stall_cnt++;
    tick();
    chk("lb_bubble", {31'd0, valid_wb}, 32'd0);
    chk("lb_hold_rd", rd_wb, 32'd5);
    dmem_gnt = 1'b1;
    #1;
    chk("lb_gwait_req", {31'd0, dmem_req}, 32'd1);
    if (stall) stall_cnt++;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("lb_rwait_req", {31'd0, dmem_req}, 32'd0);
    if (stall) stall_cnt++;
    tick();
    if (stall) stall_cnt++;
    tick();
    dmem_rvalid = 1'b1;
    #1;
    chk("lb_stall_low", {31'd0, stall}, 32'd0);
    chk("lb_stall_cycles", stall_cnt, 32'd4);
    tick();
    chk("lb_valid_wb", {31'd0, valid_wb}, 32'd1);
    chk("lb_mem_data", mem_data, 32'hFFFF_FF80);
    chk("lb_rd_wb", rd_wb, 32'd9);

    // lbu @0x103
    drive(1'b1, 5'b10_011, 3'b100, 32'd10, 32'h0000_0103, 32'h0);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
    #1;
    chk("lbu_stall0", {31'd0, stall}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    tick();
    dmem_rvalid = 1'b1;
    #1;
    chk("lbu_stall_low", {31'd0, stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    chk("lbu_mem_data", mem_data, 32'h0000_0080);

    // sh 0x1234 @0x102
    drive(1'b1, 5'b01_001, 3'b001, 32'd11, 32'h0000_0102, 32'hABCD_1234);
    dmem_gnt = 1'b1;
    #1;
    chk("sh_be", {28'd0, dmem_be}, 32'h0000_000C);
    chk("sh_wdata", w_data, 32'h1234_1234);
    chk("sh_addr", address, 32'h0000_0100);
    tick();
    chk("sh_valid_wb", {31'd0, valid_wb}, 32'd1);
    chk("sh_exc", {30'd0, exc_wb}, 32'd0);

    // lh @0x101: misaligned, no request, single-cycle completion
    drive(1'b1, 5'b10_001, 3'b001, 32'd12, 32'h0000_0101, 32'h0);
    dmem_gnt = 1'b0;
    #1;
    chk("lh_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lh_mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lh_mis_exc", {30'd0, exc_wb}, 32'd1);
    chk("lh_mis_valid", {31'd0, valid_wb}, 32'd1);
    chk("lh_mis_mem_data", mem_data, 32'd0);

    // lw @0x200: granted, never answered -> timeout
    drive(1'b1, 5'b10_010, 3'b010, 32'd13, 32'h0000_0200, 32'h0);
    dmem_gnt = 1'b1; read_data = 32'hCAFE_F00D; stall_cnt = 0;
    #1;
    chk("to_stall0", {31'd0, stall}, 32'd1);
    tick();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (stall) stall_cnt++;
      tick();
    end
    chk("to_wait_cycles", stall_cnt, 32'd15);
    chk("to_stall_low", {31'd0, stall}, 32'd0);
    tick();
    chk("to_exc", {30'd0, exc_wb}, 32'd2);
    chk("to_mem_data", mem_data, 32'd0);
    chk("to_valid_wb", {31'd0, valid_wb}, 32'd1);

    // stray response with no access pending is ignored
    valid_mem = 1'b0; dmem_rvalid = 1'b1; dmem_gnt = 1'b1;
    #1;
    chk("stray_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("stray_valid_wb", {31'd0, valid_wb}, 32'd0);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;

    // ALU ops back-to-back with a flush pulse
    drive(1'b1, 5'b00_110, 3'b010, 32'd7, 32'h1111_2222, 32'h0);
    #1;
    chk("alu_req", {31'd0, dmem_req}, 32'd0);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("alu_valid_wb", {31'd0, valid_wb}, 32'd1);
    chk("alu_data", alu_data, 32'h1111_2222);
    drive(1'b1, 5'b00_110, 3'b010, 32'd7, 32'h3333_4444, 32'h0);
    flush = 1'b1;
    #1;
    chk("alufl_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("alufl_valid_wb", {31'd0, valid_wb}, 32'd0);
    chk("alufl_data", alu_data, 32'h3333_4444);
    drive(1'b1, 5'b00_110, 3'b010, 32'd7, 32'h5555_6666, 32'h0);
    flush = 1'b0;
    tick();
    chk("alu2_valid_wb", {31'd0, valid_wb}, 32'd1);

    // flush during RWAIT: transaction completes, then a bubble
    drive(1'b1, 5'b10_010, 3'b010, 32'd14, 32'h0000_0400, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; flush = 1'b1;
    #1;
    chk("fl_mid_stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0; dmem_rvalid = 1'b1; read_data = 32'h0BAD_F00D;
    #1;
    chk("fl_mid_done", {31'd0, stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    chk("fl_mid_bubble", {31'd0, valid_wb}, 32'd0);
    chk("fl_mid_alu", alu_data, 32'h0000_0400);

    // reset while in RWAIT, then a normal load
    drive(1'b1, 5'b10_010, 3'b010, 32'd3, 32'h0000_0300, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("rw_stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_rst_stall", {31'd0, stall}, 32'd0);
    chk("rw_rst_alu", alu_data, 32'd0);
    chk("rw_rst_pc4", pc4_wb, 32'd0);
    chk("rw_rst_rd", rd_wb, 32'd0);
    #2;
    reset_n = 1'b1;
    dmem_gnt = 1'b1;
    #1;
    chk("rw_new_req", {31'd0, dmem_req}, 32'd1);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; read_data = 32'h1234_5678;
    #1;
    chk("rw_new_stall", {31'd0, stall}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    chk("rw_new_mem_data", mem_data, 32'h1234_5678);
    chk("rw_new_valid", {31'd0, valid_wb}, 32'd1);
    chk("rw_new_rd", rd_wb, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised successor to the fixed 32-bit MEM-stage pipeline register.
- Drives a handshaked data-memory port for byte, halfword and word loads and stores: lane alignment, byte enables, load sign/zero extension.
- Stalls upstream while an access is outstanding; flags misaligned accesses and bus timeouts.
- Registers results into the MEM/WB boundary and sits between EX/MEM and the writeback mux.

Parameters:
XLEN, 32, datapath/address width (32 only; byte enable width XLEN/8)
RD_W, 32, width of the rd_mem/rd_wb destination field
CTRL_WB_W, 3, width of writeback control bits carried through
TIMEOUT, 16, max cycles waiting for dmem_gnt or dmem_rvalid before bus error (>=2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_mem  in  1  instruction in MEM is valid
ctrl_mem  in  CTRL_WB_W+2  [top]=memread, [top-1]=memwrite, low CTRL_WB_W bits = writeback control
funct3_mem  in  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
rd_mem  in  RD_W  destination field
pc4_mem  in  XLEN  PC+4
alu_result  in  XLEN  effective address / ALU result
write_data1  in  XLEN  store data (unaligned, low lanes)
flush  in  1  kill instruction in MEM
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_be  out  XLEN/8  byte enables
address  out  XLEN  word-aligned address (alu_result with low 2 bits zeroed)
w_data  out  XLEN  store data shifted into lanes
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
read_data  in  XLEN  raw memory word
stall  out  1  hold upstream stages
valid_wb, ctrl_wb, rd_wb, pc4_wb, alu_data  out  1/CTRL_WB_W/RD_W/XLEN/XLEN  registered pass-through
mem_data  out  XLEN  registered extended load data
exc_wb  out  2  registered: 01 misaligned, 10 bus timeout, 00 none

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE, timeout counter 0, all registered outputs 0; dmem_req 0 and stall 0 while in reset.
- access = valid_mem & ~flush & (memread|memwrite).
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. No request is issued; completes in 1 cycle with exc=01.
- FSM states:
  - IDLE: dmem_req = access & ~misaligned (combinational). On gnt: store → done same cycle; load → RWAIT. No gnt → GWAIT.
  - GWAIT: hold req and all request outputs stable until gnt, then as IDLE.
  - RWAIT: req=0; wait for dmem_rvalid. dmem_rvalid is never asserted in the same cycle as gnt.
- stall = access & ~done. done is gnt for a store, rvalid in RWAIT for a load, or misaligned/timeout.
- Timeout counter: counts in GWAIT/RWAIT. Reaching TIMEOUT-1 forces done with exc=10, mem_data=0, and a return to IDLE. Later stray rvalid/gnt in IDLE with no access is ignored.
- Byte enables: sb 0001<<a[1:0], sh 0011<<a[1:0], sw 1111. w_data = write_data1 replicated (byte x4, half x2).
- Load extract: byte/half selected by a[1:0], sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
- WB register updates every cycle when stall=0. When stall=1, valid_wb=0 (bubble) and the other WB fields hold.
- On completion: valid_wb=valid_mem&~flush; the other fields load; latency 1 cycle after done.
- Non-memory instructions pass through in 1 cycle with no stall.
- flush in IDLE kills with no request. flush asserted mid-access is ignored: the bus transaction completes, then a bubble is issued (valid_wb=0).
- Reset mid-access abandons the transaction. The memory side must tolerate this.

Decomposition:
- Shared package mem_pkg: funct3 size encodings, exc codes, FSM state enum, ctrl bit index constants.
- Sub-module lsu_align (combinational): byte enables, store lane replication, load extraction/extension, misalign detect.
- FSM, counter and WB register stay in mem_wb_stage.

Test Plan:
- sw 0xDEADBEEF @0x100, gnt same cycle → be=1111, w_data=0xDEADBEEF, no stall, valid_wb=1 next cycle.
- lb @0x103, read_data=0x80FF_FFFF, gnt then rvalid 3 cycles later → stall 4 cycles, mem_data=0xFFFFFF80; lbu → 0x00000080.
- sh 0x1234 @0x102 → be=1100, w_data=0x12341234; lh @0x101 → no req, exc_wb=01, 1-cycle completion.
- Load with gnt but no rvalid for TIMEOUT=16 cycles → exc_wb=10, stall drops, mem_data=0.
- ALU op (ctrl memread=memwrite=0) back-to-back with flush pulse → no req, valid_wb follows ~flush, alu_data=alu_result.
- reset_n low during RWAIT → all outputs 0 immediately, dmem_req=0, next load accepted normally.
